// File: rtl/counter_ctrl_if.sv
// counter_ctrl_if
//   Control/status bundle for counter_ctrl.
//   master (controller side) drives: start, stop, pause, mode, term_val, presc
//   master samples:                  q_counter, busy, paused, tc, done
//   slave  (counter_ctrl side) has the opposite directions.
interface counter_ctrl_if #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 4
);
  logic               start;
  logic               stop;
  logic               pause;
  logic               mode;
  logic [WIDTH-1:0]   term_val;
  logic [PRESC_W-1:0] presc;
  logic [WIDTH-1:0]   q_counter;
  logic               busy;
  logic               paused;
  logic               tc;
  logic               done;

  modport master (
    output start, stop, pause, mode, term_val, presc,
    input  q_counter, busy, paused, tc, done
  );

  modport slave (
    input  start, stop, pause, mode, term_val, presc,
    output q_counter, busy, paused, tc, done
  );
endinterface

// File: rtl/counter_ctrl.sv
// counter_ctrl
//   Programmable up-counter with one-shot / periodic modes, pause and abort.
//   A start request latches mode, terminal value and prescaler reload, then the
//   count advances once per tick from 0 up to the terminal value. In periodic
//   mode the count wraps to 0 on the terminal event; in one-shot mode it stops
//   at the terminal value in DONE.
//
// Ports
//   clock : single clock, rising edge
//   rst   : asynchronous active-low reset
//   bus   : counter_ctrl_if.slave
//             in : start, stop, pause, mode, term_val[WIDTH], presc[PRESC_W]
//             out: q_counter[WIDTH], busy, paused, tc (every terminal event),
//                  done (one-shot terminal event only); all registered
//
// Configuration
//   COUNTER_CTRL_PRESCALE_EN defined  : tick when prescaler reaches presc
//                                       (presc = 0 ticks every cycle).
//   COUNTER_CTRL_PRESCALE_EN undefined: no prescaler, tick every RUN cycle;
//                                       presc is accepted and ignored.
module counter_ctrl #(
  parameter int unsigned WIDTH   = 4,
  parameter int unsigned PRESC_W = 4
) (
  input logic           clock,
  input logic           rst,
  counter_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t           state_r, state_n;
  logic [WIDTH-1:0] q_r, q_n;
  logic [WIDTH-1:0] term_r, term_n;
  logic             mode_r, mode_n;
  logic             busy_r, busy_n;
  logic             paused_r, paused_n;
  logic             tc_r, tc_n;
  logic             done_r, done_n;
  logic             tick;

`ifdef COUNTER_CTRL_PRESCALE_EN
  logic [PRESC_W-1:0] pcnt_r, pcnt_n;
  logic [PRESC_W-1:0] presc_r, presc_n;
`else
  logic presc_unused;
  assign presc_unused = ^bus.presc;
`endif

  // State and datapath registers
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      q_r      <= '0;
      term_r   <= '0;
      mode_r   <= 1'b0;
      busy_r   <= 1'b0;
      paused_r <= 1'b0;
      tc_r     <= 1'b0;
      done_r   <= 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      pcnt_r   <= '0;
      presc_r  <= '0;
`endif
    end else begin
      state_r  <= state_n;
      q_r      <= q_n;
      term_r   <= term_n;
      mode_r   <= mode_n;
      busy_r   <= busy_n;
      paused_r <= paused_n;
      tc_r     <= tc_n;
      done_r   <= done_n;
`ifdef COUNTER_CTRL_PRESCALE_EN
      pcnt_r   <= pcnt_n;
      presc_r  <= presc_n;
`endif
    end
  end

  // Next-state and next-output logic. Priority is stop > pause > start.
  always_comb begin
    state_n = state_r;
    q_n     = q_r;
    term_n  = term_r;
    mode_n  = mode_r;
    tc_n    = 1'b0;
    done_n  = 1'b0;
    tick    = 1'b0;
`ifdef COUNTER_CTRL_PRESCALE_EN
    pcnt_n  = pcnt_r;
    presc_n = presc_r;
`endif

    if (bus.stop) begin
      state_n = S_IDLE;
      q_n     = '0;
`ifdef COUNTER_CTRL_PRESCALE_EN
      pcnt_n  = '0;
`endif
    end else begin
      unique case (state_r)
        S_IDLE, S_DONE: begin
          // pause is ignored here; DONE keeps q at term until restarted
          if (bus.start) begin
            state_n = S_RUN;
            q_n     = '0;
            term_n  = bus.term_val;
            mode_n  = bus.mode;
`ifdef COUNTER_CTRL_PRESCALE_EN
            pcnt_n  = '0;
            presc_n = bus.presc;
`endif
          end
        end

        S_RUN: begin
          if (bus.pause) begin
            // count and prescaler freeze; a tick due on this edge is dropped
            state_n = S_PAUSE;
          end else begin
`ifdef COUNTER_CTRL_PRESCALE_EN
            tick   = (pcnt_r == presc_r);
            pcnt_n = tick ? '0 : pcnt_r + PRESC_W'(1);
`else
            tick   = 1'b1;
`endif
            if (tick) begin
              if (q_r == term_r) begin
                tc_n = 1'b1;
                if (mode_r) begin
                  q_n = '0;
                end else begin
                  state_n = S_DONE;
                  done_n  = 1'b1;
                end
              end else begin
                q_n = q_r + WIDTH'(1);
              end
            end
          end
        end

        S_PAUSE: begin
          // the release edge only changes state; counting resumes after it
          if (!bus.pause) state_n = S_RUN;
        end

        default: state_n = S_IDLE;
      endcase
    end

    busy_n   = (state_n == S_RUN) || (state_n == S_PAUSE);
    paused_n = (state_n == S_PAUSE);
  end

  assign bus.q_counter = q_r;
  assign bus.busy      = busy_r;
  assign bus.paused    = paused_r;
  assign bus.tc        = tc_r;
  assign bus.done      = done_r;

endmodule
